bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It takes one unsigned binary word per start request and produces packed BCD digits after a fixed number of cycles. It sits between the binary datapath (counters, switch inputs, ALU results) and the seven-segment digit multiplexer, which consumes the held BCD output.

## Interface
- WIDTH, 8: width of the unsigned binary input, in bits (1..16).
- DIGITS, 3: number of BCD output digits. Elaboration fails unless 10^DIGITS > 2^WIDTH − 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  unsigned value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd is valid from this cycle onward.
- bcd  output  4*DIGITS  packed result, digit 0 (ones) in bits [3:0]; held until the next done.

## Operation
- Reset values: state IDLE, busy=0, done=0, bcd=0, and all internal registers 0.
- States are IDLE and CONV.
- IDLE with start=1:
  - Load bin into the binary shift register.
  - Clear the BCD scratch register.
  - Set the bit counter to WIDTH.
  - Go to CONV and set busy=1.
- IDLE with start=0: hold.
- CONV, each cycle, in order:
  - Every scratch digit ≥ 5 gets +3. All digits adjust in parallel in the same cycle.
  - Shift {scratch, binary} left by one. The binary MSB enters scratch bit 0.
  - Decrement the counter.
- CONV with counter = 1:
  - Perform the final adjust-and-shift.
  - Load the shifted scratch value into bcd.
  - Set done=1, busy=0 and go to IDLE.
- start while in CONV is ignored. No queuing. bin changes while busy have no effect.
- Digit adjust is 4-bit. Inputs 0..9 are the only legal values and the result never exceeds 4 bits (5..9 map to 8..12).
- Counter width is $clog2(WIDTH+1). The counter never wraps in legal operation.
- Reset asserted mid-conversion:
  - All state clears immediately (asynchronous).
  - The partial result is discarded and bcd returns to 0.
  - No done is produced.
- The IDLE-cycle adjust/shift logic does not modify bcd. bcd changes only on the edge that raises done, or on reset.

## Timing
- The accepting edge is E0. Shifts happen at edges E1..E(WIDTH−1), and the final shift plus output load happens at E(WIDTH).
- busy is high from after E0 through E(WIDTH). done and the new bcd are visible for the cycle after E(WIDTH).
- Start-to-done latency is WIDTH+1 clock edges counting the accepting edge. For the default, start is sampled at cycle 0 and done is high in cycle 9.
- Back-to-back: start asserted in the done cycle is accepted, since the state is IDLE. Throughput is one conversion per WIDTH+1 cycles.
- done is high for exactly one cycle. The prior bcd stays stable during CONV.

## Structure
- Package bin2bcd_pkg holds:
  - typedef state_t {IDLE, CONV};
  - typedef bcd_digit_t (logic [3:0]);
  - constants ADJ_THRESH=5 and ADJ_ADD=3.
- Sub-module bcd_digit_adj: combinational, 4-bit in, 4-bit out (in ≥ 5 ? in+3 : in). It is instantiated DIGITS times with a generate loop.
- The top holds the FSM, counter, shift registers and output register. Target is roughly 150 lines.

## Test plan
- Zero and max (WIDTH=8, DIGITS=3): start with bin=0 gives bcd=0x000, done in cycle 9. Start with bin=255 gives bcd=0x255.
- Adjust threshold: bin=5 gives 0x005, bin=99 gives 0x099, bin=100 gives 0x100. busy=1 for exactly 8 cycles, and done is a single-cycle pulse each time.
- Ignored start: start with bin=200, then re-pulse start with bin=17 in cycle 3. Result is 0x200, with exactly one done and bcd unchanged until then.
- Back-to-back: bin=128, then start=1 with bin=64 in the done cycle. Result is 0x128 and then 0x064 nine cycles later, with no idle gap.
- Reset mid-operation: start with bin=231 and drop rst_n in cycle 4. busy, done and bcd go to 0 immediately, and no done follows. After release, bin=42 gives 0x042.
- Exhaustive sweep: every bin in 0..255 sequentially. Each bcd digit must be ≤ 9 and the decoded value must equal bin, checked against a reference model.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// pow10 lets the top reject a DIGITS/WIDTH pairing that cannot hold the maximum input.
package bin2bcd_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t ADJ_THRESH = 4'd5;
  localparam bcd_digit_t ADJ_ADD    = 4'd3;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 so the following
// left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  bcd_digit_t digit;

  assign digit = din;
  assign dout  = (digit >= ADJ_THRESH) ? digit + ADJ_ADD : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one input bit per CONV
// cycle, result held in bcd from the done pulse until the next conversion.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;

  generate
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   bin_reg;
  logic [BCD_W-1:0]   scratch_reg;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   bcd_reg;
  logic               done_reg;
  logic [SR_W-1:0]    sr_next;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (scratch_reg[4*gi +: 4]),
        .dout (scratch_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Adjusted scratch and binary shift as one register so the binary MSB
  // falls into scratch bit 0; the scratch MSB is always zero after adjust.
  assign sr_next = {scratch_adj, bin_reg} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bin_reg     <= '0;
      scratch_reg <= '0;
      bcd_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg     <= bin;
            scratch_reg <= '0;
            cnt_reg     <= CNT_W'(WIDTH);
            state_reg   <= CONV;
          end
        end
        CONV: begin
          scratch_reg <= sr_next[SR_W-1:WIDTH];
          bin_reg     <= sr_next[WIDTH-1:0];
          cnt_reg     <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            bcd_reg   <= sr_next[SR_W-1:WIDTH];
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg == CONV);
  assign done = done_reg;
  assign bcd  = bcd_reg;

endmodule
